mul8u_share_arb: RTL and testbench

- Time-shares one combinational 8x8 unsigned multiplier (exact or approximate `mul8u_*` variant) among NREQ requesters.
- Round-robin arbitration feeds a 2-stage pipeline: operand register, then result register.
- The multiplier instance sits outside this block, connected through mul_a/mul_b/mul_o, so any variant can be swapped in without touching the controller.

---
 rtl/mul8u_share_arb.sv | 149 ++++++++++++++
 tb/tb_mul8u_share_arb.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8u_share_arb.sv
// Round-robin sharing of one external 8x8 unsigned multiplier among NREQ requesters,
// via an operand stage and a result stage. Define MUL8U_ERRSTAT_EN for error statistics.
module mul8u_share_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_prod,
  output logic              busy
`ifdef MUL8U_ERRSTAT_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       err_cnt,
  output logic [31:0]       ops_cnt,
  output logic [15:0]       err_max
`endif
);

  localparam int unsigned OPW = 8;
  localparam int unsigned PW  = 16;
  localparam int unsigned XW  = IDW + 1;

  logic           r_s1_v;
  logic [OPW-1:0] r_s1_a;
  logic [OPW-1:0] r_s1_b;
  logic [IDW-1:0] r_s1_id;
  logic           r_s2_v;
  logic [PW-1:0]  r_s2_prod;
  logic [IDW-1:0] r_s2_id;
  logic [IDW-1:0] r_rr_ptr;

  logic           w_s2_load;
  logic           w_s1_free;
  logic           w_grant_found;
  logic [IDW-1:0] w_grant_id;
  logic [XW-1:0]  w_idx;
  logic           w_hs;
  logic [OPW-1:0] w_sel_a;
  logic [OPW-1:0] w_sel_b;

  assign w_s2_load = r_s1_v & (~r_s2_v | rsp_ready);
  assign w_s1_free = ~r_s1_v | w_s2_load;

  // Rotating search starting just after the last granted requester
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_idx         = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      w_idx = XW'(r_rr_ptr) + XW'(k);
      if (w_idx >= XW'(NREQ)) w_idx = w_idx - XW'(NREQ);
      if (!w_grant_found && req_valid[IDW'(w_idx)]) begin
        w_grant_found = 1'b1;
        w_grant_id    = IDW'(w_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_grant_found) req_ready[w_grant_id] = w_s1_free;
  end

  assign w_hs    = w_grant_found & w_s1_free;
  assign w_sel_a = req_a[OPW*int'(w_grant_id) +: OPW];
  assign w_sel_b = req_b[OPW*int'(w_grant_id) +: OPW];

  // Operand stage, result stage and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_id   <= '0;
      r_s2_v    <= 1'b0;
      r_s2_prod <= '0;
      r_s2_id   <= '0;
      r_rr_ptr  <= IDW'(NREQ - 1);
    end else begin
      if (w_hs) begin
        r_s1_v   <= 1'b1;
        r_s1_a   <= w_sel_a;
        r_s1_b   <= w_sel_b;
        r_s1_id  <= w_grant_id;
        r_rr_ptr <= w_grant_id;
      end else if (w_s2_load) begin
        r_s1_v <= 1'b0;
      end
      if (w_s2_load) begin
        r_s2_v    <= 1'b1;
        r_s2_prod <= mul_o;
        r_s2_id   <= r_s1_id;
      end else if (rsp_ready) begin
        r_s2_v <= 1'b0;
      end
    end
  end

  assign mul_a     = r_s1_a;
  assign mul_b     = r_s1_b;
  assign rsp_valid = r_s2_v;
  assign rsp_prod  = r_s2_prod;
  assign rsp_id    = r_s2_id;
  assign busy      = r_s1_v | r_s2_v;

`ifdef MUL8U_ERRSTAT_EN
  logic [31:0]   r_err_cnt;
  logic [31:0]   r_ops_cnt;
  logic [PW-1:0] r_err_max;
  logic [PW-1:0] w_exact;
  logic [PW-1:0] w_diff;

  assign w_exact = PW'(r_s1_a) * PW'(r_s1_b);
  assign w_diff  = (w_exact >= mul_o) ? (w_exact - mul_o) : (mul_o - w_exact);

  // Saturating counters and running max error, sampled when a product is captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
      r_ops_cnt <= '0;
      r_err_max <= '0;
    end else if (stat_clr) begin
      r_err_cnt <= '0;
      r_ops_cnt <= '0;
      r_err_max <= '0;
    end else if (w_s2_load) begin
      if (r_ops_cnt != '1) r_ops_cnt <= r_ops_cnt + 32'd1;
      if ((w_diff != '0) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 32'd1;
      if (w_diff > r_err_max) r_err_max <= w_diff;
    end
  end

  assign err_cnt = r_err_cnt;
  assign ops_cnt = r_ops_cnt;
  assign err_max = r_err_max;
`endif

endmodule

// File: tb/tb_mul8u_share_arb.sv
// Self-checking bench for mul8u_share_arb: directed scenarios plus randomized traffic
// checked by a transaction-level scoreboard (round-robin pick, in-flight queue).
module tb_mul8u_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [15:0]       mul_o;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_prod;
  logic              busy;
`ifdef MUL8U_ERRSTAT_EN
  logic              stat_clr;
  logic [31:0]       err_cnt;
  logic [31:0]       ops_cnt;
  logic [15:0]       err_max;
`endif

  mul8u_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
    .busy(busy)
`ifdef MUL8U_ERRSTAT_EN
    , .stat_clr(stat_clr), .err_cnt(err_cnt), .ops_cnt(ops_cnt), .err_max(err_max)
`endif
  );

  // External multiplier: exact, or a stub that is 16 low for 255x255
  always_comb begin
    mul_o = 16'(mul_a) * 16'(mul_b);
`ifdef MUL8U_ERRSTAT_EN
    if (mul_a == 8'hFF && mul_b == 8'hFF) mul_o = mul_o - 16'd16;
`endif
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int ref_mul(input int a, input int b);
    int p;
    p = a * b;
`ifdef MUL8U_ERRSTAT_EN
    if (a == 255 && b == 255) p = p - 16;
`endif
    return p;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int k = 1; k <= NREQ; k++)
      if (r < 0 && v[(ptr + k) % NREQ]) r = (ptr + k) % NREQ;
    return r;
  endfunction

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // Scoreboard state, owned by the monitor
  typedef struct { int id; int prod; int acc; } exp_t;
  exp_t            q[$];
  exp_t            e;
  int              m_ptr = NREQ - 1;
  int              cyc = 0;
  int              hs_count = 0;
  int              mw;
  logic            mon_en = 1'b0;
  logic            exp_rv;
  logic [NREQ-1:0] exp_rdy;
  logic [NREQ-1:0] last_hs = '0;
  logic [NREQ-1:0] p_valid = '0;
  logic [8*NREQ-1:0] p_a, p_b;
  logic            p_rv = 1'b0;
  logic            p_rr = 1'b0;
  logic [15:0]     p_prod;
  logic [IDW-1:0]  p_id;

  // Monitor on the falling edge: inputs are stable and predict the next rising edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_en && rst_n) begin
      mw = rr_pick(m_ptr, req_valid);
      exp_rdy = '0;
      if (mw >= 0 && (q.size() < 2 || rsp_ready)) exp_rdy[mw] = 1'b1;
      n_chk++;
      if (req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL req_ready: got %b expected %b at cycle %0d", req_ready, exp_rdy, cyc);
      end
      exp_rv = 1'b0;
      if (q.size() > 0) exp_rv = (q[0].acc <= cyc - 2);
      n_chk++;
      if (rsp_valid !== exp_rv) begin
        n_fail++;
        $display("FAIL rsp_valid: got %b expected %b at cycle %0d", rsp_valid, exp_rv, cyc);
      end
      if (exp_rv && rsp_valid === 1'b1) begin
        n_chk++;
        if (rsp_id !== IDW'(q[0].id) || rsp_prod !== 16'(q[0].prod)) begin
          n_fail++;
          $display("FAIL rsp_data: got id=%0d prod=%h expected id=%0d prod=%h", rsp_id, rsp_prod,
                   q[0].id, 16'(q[0].prod));
        end
      end
      n_chk++;
      if (busy !== (q.size() > 0)) begin
        n_fail++;
        $display("FAIL busy: got %b expected %b at cycle %0d", busy, q.size() > 0, cyc);
      end
      if (p_rv && !p_rr) begin
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_prod !== p_prod || rsp_id !== p_id) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b id=%0d prod=%h expected v=1 id=%0d prod=%h",
                   rsp_valid, rsp_id, rsp_prod, p_id, p_prod);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (p_valid[i] && !last_hs[i]) begin
          n_chk++;
          if (!req_valid[i] || req_a[8*i +: 8] !== p_a[8*i +: 8] || req_b[8*i +: 8] !== p_b[8*i +: 8]) begin
            n_fail++;
            $display("FAIL protocol: requester %0d got valid=%b expected held request", i, req_valid[i]);
          end
        end
      end
      if (rsp_valid === 1'b1 && rsp_ready && q.size() > 0) void'(q.pop_front());
      last_hs = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (last_hs[i]) begin
          e.id   = i;
          e.prod = ref_mul(int'(req_a[8*i +: 8]), int'(req_b[8*i +: 8]));
          e.acc  = cyc;
          q.push_back(e);
          m_ptr = i;
          hs_count++;
        end
      end
      p_valid = req_valid;
      p_a     = req_a;
      p_b     = req_b;
      p_rv    = rsp_valid;
      p_rr    = rsp_ready;
      p_prod  = rsp_prod;
      p_id    = rsp_id;
    end else begin
      q.delete();
      m_ptr   = NREQ - 1;
      last_hs = '0;
      p_valid = '0;
      p_rv    = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]     = v;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  task automatic drop_accepted();
    req_valid = req_valid & ~last_hs;
  endtask

  task automatic apply_reset();
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
`ifdef MUL8U_ERRSTAT_EN
    stat_clr  = 1'b0;
`endif
    repeat (3) tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      drop_accepted();
      if (req_valid == '0 && q.size() == 0) break;
    end
    n_chk++;
    if (req_valid != '0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending requests and %0d in flight expected 0", $countones(req_valid), q.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_prod !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: got v=%b id=%0d prod=%h expected 0", rsp_valid, rsp_id, rsp_prod);
    end
    n_chk++;
    if (mul_a !== 8'h00 || mul_b !== 8'h00 || busy !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_misc: got mul_a=%h mul_b=%h busy=%b req_ready=%b expected 0", mul_a, mul_b, busy, req_ready);
    end
  endtask

  task automatic test_single_max();
    apply_reset();
    rsp_ready = 1'b1;
    set_lane(0, 1'b1, 8'hFF, 8'hFF);
    tick();
    req_valid = '0;
    n_chk++;
    if (rsp_valid !== 1'b0 || mul_a !== 8'hFF || mul_b !== 8'hFF) begin
      n_fail++;
      $display("FAIL single_s1: got v=%b mul_a=%h mul_b=%h expected v=0 ff ff", rsp_valid, mul_a, mul_b);
    end
    tick();
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_prod !== 16'(ref_mul(255, 255)) || rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%b id=%0d prod=%h expected v=1 id=0 prod=%h", rsp_valid, rsp_id,
               rsp_prod, 16'(ref_mul(255, 255)));
    end
    tick();
    n_chk++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b v=%b expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_all_rr();
    int order [6] = '{0, 1, 2, 3, 0, 1};
    logic [NREQ-1:0] want;
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, rnd8(), rnd8());
    for (int k = 0; k < 6; k++) begin
      tick();
      want = '0;
      want[order[k]] = 1'b1;
      n_chk++;
      if (last_hs !== want) begin
        n_fail++;
        $display("FAIL rr_order: step %0d got grant %b expected %b", k, last_hs, want);
      end
      for (int i = 0; i < NREQ; i++)
        if (last_hs[i]) set_lane(i, 1'b1, rnd8(), rnd8());
    end
    drain();
  endtask

  task automatic test_join();
    apply_reset();
    rsp_ready = 1'b1;
    set_lane(2, 1'b1, rnd8(), rnd8());
    tick();
    n_chk++;
    if (last_hs !== 4'b0100) begin
      n_fail++;
      $display("FAIL join_first: got %b expected 0100", last_hs);
    end
    drop_accepted();
    set_lane(1, 1'b1, rnd8(), rnd8());
    set_lane(3, 1'b1, rnd8(), rnd8());
    tick();
    n_chk++;
    if (last_hs !== 4'b1000) begin
      n_fail++;
      $display("FAIL join_second: got %b expected 1000", last_hs);
    end
    drop_accepted();
    tick();
    n_chk++;
    if (last_hs !== 4'b0010) begin
      n_fail++;
      $display("FAIL join_third: got %b expected 0010", last_hs);
    end
    drain();
  endtask

  task automatic test_stall();
    int h0;
    logic [15:0] hold_prod;
    logic [7:0]  hold_a;
    apply_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_lane(i, 1'b1, rnd8(), rnd8());
    h0 = hs_count;
    hold_prod = '0;
    hold_a    = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      drop_accepted();
      if (k == 2) begin
        hold_prod = rsp_prod;
        hold_a    = mul_a;
      end
    end
    n_chk++;
    if (hs_count - h0 !== 2) begin
      n_fail++;
      $display("FAIL stall_accepts: got %0d expected 2", hs_count - h0);
    end
    n_chk++;
    if (req_ready !== '0 || rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_ready: got req_ready=%b rsp_valid=%b expected 0000 1", req_ready, rsp_valid);
    end
    n_chk++;
    if (rsp_prod !== hold_prod || mul_a !== hold_a) begin
      n_fail++;
      $display("FAIL stall_stable: got prod=%h mul_a=%h expected %h %h", rsp_prod, mul_a, hold_prod, hold_a);
    end
    drain();
    n_chk++;
    if (hs_count - h0 !== 3) begin
      n_fail++;
      $display("FAIL stall_total: got %0d expected 3", hs_count - h0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rsp_ready = 1'b0;
    set_lane(0, 1'b1, rnd8(), rnd8());
    set_lane(1, 1'b1, rnd8(), rnd8());
    repeat (2) begin
      tick();
      drop_accepted();
    end
    n_chk++;
    if (busy !== 1'b1 || rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_full: got busy=%b v=%b expected 1 1", busy, rsp_valid);
    end
    #2;
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    n_chk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || mul_a !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_clear: got v=%b busy=%b mul_a=%h expected 0 0 00", rsp_valid, busy, mul_a);
    end
    repeat (2) tick();
    rst_n     = 1'b1;
    mon_en    = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, rnd8(), rnd8());
    tick();
    n_chk++;
    if (last_hs !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_first: got %b expected 0001", last_hs);
    end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick();
      drop_accepted();
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_lane(i, 1'b1, rnd8(), rnd8());
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
  endtask

`ifdef MUL8U_ERRSTAT_EN
  task automatic test_errstat();
    logic [7:0] opa [3] = '{8'hFF, 8'd3, 8'hFF};
    logic [7:0] opb [3] = '{8'hFF, 8'd5, 8'hFF};
    apply_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_lane(0, 1'b1, opa[k], opb[k]);
      tick();
    end
    drain();
    n_chk++;
    if (ops_cnt !== 32'd3 || err_cnt !== 32'd2 || err_max !== 16'd16) begin
      n_fail++;
      $display("FAIL errstat: got ops=%0d err=%0d max=%0d expected 3 2 16", ops_cnt, err_cnt, err_max);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    n_chk++;
    if (ops_cnt !== 32'd0 || err_cnt !== 32'd0 || err_max !== 16'd0) begin
      n_fail++;
      $display("FAIL errstat_clr: got ops=%0d err=%0d max=%0d expected 0 0 0", ops_cnt, err_cnt, err_max);
    end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
`ifdef MUL8U_ERRSTAT_EN
    stat_clr  = 1'b0;
`endif
    test_reset();
    test_single_max();
    test_all_rr();
    test_join();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef MUL8U_ERRSTAT_EN
    test_errstat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
